// File: rtl/wb_pkg.sv
// Shared types for the writeback controller: register address width and the
// queued ALU result entry.
package wb_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/writeback_ctrl_if.sv
// Writeback bus: issue notifications, ALU/load result offers, register-file
// write port and status. master drives results, slave is the controller.
interface writeback_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            mem_valid;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            reg_we;
   logic [4:0]      destreg_num;
   logic [XLEN-1:0] write_value;
   logic [31:0]     busy_mask;
   logic [CW-1:0]   fifo_count;

   modport master (
      output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
             mem_valid, mem_rd, mem_data,
      input  alu_ready, reg_we, destreg_num, write_value, busy_mask, fifo_count
   );

   modport slave (
      input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
             mem_valid, mem_rd, mem_data,
      output alu_ready, reg_we, destreg_num, write_value, busy_mask, fifo_count
   );
endinterface

// File: rtl/wb_fifo.sv
// Small circular FIFO holding ALU results that lost arbitration to a load.
// Push is ignored when full and pop when empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  wb_entry_t     push_data_i,
   input  logic          pop_i,
   output wb_entry_t     head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   wb_entry_t     mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
   // the increment wrap on its own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end
endmodule

// File: rtl/writeback_ctrl.sv
// Writeback arbiter: one register-file write per cycle, loads first, then
// queued ALU results, then a bypassing ALU result. Tracks busy registers.
module writeback_ctrl
   import wb_pkg::REG_ADDR_W;
   import wb_pkg::wb_entry_t;
#(
   parameter int XLEN  = wb_pkg::XLEN,
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              rst_n,
   writeback_ctrl_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t             head, sel, alu_entry;
   logic                  sel_vld, push, pop, alu_hs;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         fifo_count;
   logic                  reg_we_q, reg_we_d;
   logic [REG_ADDR_W-1:0] destreg_q, destreg_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [31:0]           busy_q, busy_d, busy_set, busy_clr;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (alu_entry),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};
   // An empty FIFO can still take a result under a load; only a full one stalls.
   assign bus.alu_ready = !fifo_full || (fifo_empty && !bus.mem_valid);
   assign alu_hs        = bus.alu_valid && bus.alu_ready;

   always_comb begin
      sel_vld = 1'b0;
      sel     = '0;
      push    = 1'b0;
      pop     = 1'b0;
      if (bus.mem_valid) begin
         sel_vld = 1'b1;
         sel     = '{rd: bus.mem_rd, data: bus.mem_data};
         push    = alu_hs;
      end else if (!fifo_empty) begin
         sel_vld = 1'b1;
         sel     = head;
         pop     = 1'b1;
         push    = alu_hs;
      end else if (alu_hs) begin
         sel_vld = 1'b1;
         sel     = alu_entry;
      end
   end

   // x0 writes are consumed but never reach the register file.
   always_comb begin
      reg_we_d  = sel_vld && (sel.rd != '0);
      destreg_d = destreg_q;
      wdata_d   = wdata_q;
      if (reg_we_d) begin
         destreg_d = sel.rd;
         wdata_d   = sel.data;
      end
      busy_set = (bus.issue_valid && bus.issue_rd != '0) ? (32'd1 << bus.issue_rd) : '0;
      busy_clr = sel_vld ? (32'd1 << sel.rd) : '0;
      busy_d   = ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_we_q  <= 1'b0;
         destreg_q <= '0;
         wdata_q   <= '0;
         busy_q    <= '0;
      end else begin
         reg_we_q  <= reg_we_d;
         destreg_q <= destreg_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.reg_we      = reg_we_q;
   assign bus.destreg_num = destreg_q;
   assign bus.write_value = wdata_q;
   assign bus.busy_mask   = busy_q;
   assign bus.fifo_count  = fifo_count;
endmodule

// File: tb/tb_writeback_ctrl.sv
// Self-checking bench for writeback_ctrl: a reference queue model predicts
// every register write into a scoreboard that the write monitor drains.
module tb_writeback_ctrl;
   import wb_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_ctrl_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

   writeback_ctrl #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   wb_entry_t   sb[$];
   wb_entry_t   mq[$];
   logic [31:0] bm = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Write monitor: every reg_we pulse must match the oldest predicted write.
   always @(negedge clk) begin : mon
      wb_entry_t e;
      if (rst_n && bus.reg_we) begin
         if (sb.size() == 0) chk("unexp_we", 1, 0);
         else begin
            e = sb.pop_front();
            chk("wr_rd", bus.destreg_num, e.rd);
            chk("wr_data", bus.write_value, e.data);
         end
      end
   end

   task automatic clr_inputs();
      bus.issue_valid = 0; bus.issue_rd = 0;
      bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
      bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
   endtask

   // One clock cycle: drive, check state against the model, advance the model.
   task automatic step(input logic iv, input logic [4:0] ird,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       output logic acc);
      logic      rdy, sv;
      wb_entry_t s;
      @(negedge clk);
      bus.issue_valid = iv; bus.issue_rd = ird;
      bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
      bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
      #1;
      rdy = (mq.size() < DEPTH) || (mq.size() == 0 && !mv);
      chk("alu_ready", bus.alu_ready, rdy);
      chk("fifo_count", bus.fifo_count, mq.size());
      chk("busy_mask", bus.busy_mask, bm);
      acc = av && rdy;
      sv = 0;
      s  = '0;
      if (mv) begin
         sv = 1; s = '{mrd, md};
         if (acc) mq.push_back('{ard, ad});
      end else if (mq.size() > 0) begin
         sv = 1; s = mq.pop_front();
         if (acc) mq.push_back('{ard, ad});
      end else if (acc) begin
         sv = 1; s = '{ard, ad};
      end
      if (sv && s.rd != 0) sb.push_back(s);
      if (sv) bm[s.rd] = 1'b0;
      if (iv && ird != 0) bm[ird] = 1'b1;
      bm[0] = 1'b0;
      @(posedge clk);
      #1;
      clr_inputs();
   endtask

   task automatic idle();
      logic a;
      step(0, 0, 0, 0, 0, 0, 0, 0, a);
   endtask

   initial begin
      logic        a;
      logic [5:0]  accv;
      int          k;
      logic        pend;
      logic [4:0]  prd;
      logic [31:0] pdat;
      clr_inputs();
      #1;
      chk("rst_we", bus.reg_we, 0);
      chk("rst_busy", bus.busy_mask, 0);
      chk("rst_cnt", bus.fifo_count, 0);
      chk("rst_rd", bus.destreg_num, 0);
      chk("rst_val", bus.write_value, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU bypass into an empty FIFO.
      step(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, a);
      chk("byp_we", bus.reg_we, 1);
      chk("byp_rd", bus.destreg_num, 5);
      chk("byp_val", bus.write_value, 32'hDEADBEEF);
      chk("byp_cnt", bus.fifo_count, 0);

      // Load and ALU collide: load first, ALU one cycle later via the FIFO.
      step(0, 0, 1, 5'd4, 32'h22, 1, 5'd3, 32'h11, a);
      chk("col1_rd", bus.destreg_num, 3);
      chk("col1_val", bus.write_value, 32'h11);
      chk("col1_cnt", bus.fifo_count, 1);
      idle();
      chk("col2_we", bus.reg_we, 1);
      chk("col2_rd", bus.destreg_num, 4);
      chk("col2_val", bus.write_value, 32'h22);
      chk("col2_cnt", bus.fifo_count, 0);

      // Sustained loads fill the FIFO; ALU stalls after four entries.
      k = 0;
      for (int c = 0; c < 6; c++) begin
         step(0, 0, 1, 5'(10 + k), 32'hA000 + k, 1, 5'(20 + c), 32'hB000 + c, a);
         accv[c] = a;
         if (a) k++;
      end
      chk("full_acc", accv, 6'b001111);
      chk("full_cnt", bus.fifo_count, DEPTH);
      for (int c = 0; c < 30 && (k < 6 || mq.size() > 0); c++) begin
         step(0, 0, k < 6, 5'(10 + k), 32'hA000 + k, 0, 0, 0, a);
         if (a) k++;
      end
      chk("full_drain", (k == 6) && (mq.size() == 0), 1);

      // Busy tracking: set beats clear on the same register, x0 never busy.
      step(1, 5'd7, 0, 0, 0, 0, 0, 0, a);
      chk("busy7_set", bus.busy_mask[7], 1);
      step(1, 5'd7, 1, 5'd7, 32'h77, 0, 0, 0, a);
      chk("busy7_hold", bus.busy_mask[7], 1);
      step(1, 5'd0, 0, 0, 0, 0, 0, 0, a);
      chk("busy0", bus.busy_mask[0], 0);
      step(0, 0, 1, 5'd7, 32'h78, 0, 0, 0, a);
      chk("busy7_clr", bus.busy_mask[7], 0);

      // x0 write is swallowed.
      step(0, 0, 1, 5'd0, 32'hFFFF, 0, 0, 0, a);
      chk("x0_acc", a, 1);
      chk("x0_we", bus.reg_we, 0);

      // Reset with three queued results.
      for (int c = 0; c < 3; c++)
         step(1, 5'd9, 1, 5'(12 + c), 32'hC0 + c, 1, 5'(2 + c), 32'hD0 + c, a);
      chk("pre_rst_cnt", bus.fifo_count, 3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", bus.fifo_count, 0);
      chk("mid_rst_busy", bus.busy_mask, 0);
      chk("mid_rst_we", bus.reg_we, 0);
      mq.delete();
      sb.delete();
      bm = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         idle();
         chk("post_rst_we", bus.reg_we, 0);
      end

      // Random traffic against the model.
      pend = 0; prd = 0; pdat = 0;
      for (int c = 0; c < 120; c++) begin
         if (!pend && $urandom_range(0, 9) < 7) begin
            pend = 1; prd = 5'($urandom_range(0, 31)); pdat = $urandom;
         end
         step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
              pend, prd, pdat,
              $urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom, a);
         if (a) pend = 0;
      end
      for (int c = 0; c < 20 && mq.size() > 0; c++) idle();
      idle();
      idle();
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/writeback_ctrl.md
WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width.
REQ-002 Parameter DEPTH, default 4, SHALL set the ALU result FIFO depth (power of two, at least 2).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 issue_valid  in  1  SHALL mark that an instruction writing issue_rd was issued this cycle.
REQ-006 issue_rd  in  5  SHALL be the destination register of the issued instruction.
REQ-007 alu_valid  in  1  SHALL be asserted when an ALU result is offered.
REQ-008 alu_ready  out  1  SHALL be asserted when an ALU result is accepted this cycle.
REQ-009 alu_rd / alu_data  in  5 / XLEN  SHALL be the ALU destination and value.
REQ-010 mem_valid  in  1  SHALL be asserted when a load result is offered; it is always accepted.
REQ-011 mem_rd / mem_data  in  5 / XLEN  SHALL be the load destination and value.
REQ-012 reg_we  out  1  SHALL be the register-file write enable, registered.
REQ-013 destreg_num / write_value  out  5 / XLEN  SHALL be the registered write address and data.
REQ-014 busy_mask  out  32  SHALL flag registers with an outstanding write.
REQ-015 fifo_count  out  log2(DEPTH)+1  SHALL report ALU FIFO occupancy.

Function
REQ-016 The block SHALL select at most one write per cycle; selected at edge N means reg_we high during cycle N+1.
REQ-017 Priority SHALL be: mem result, then FIFO head, then a live ALU result bypassing an empty FIFO.
REQ-018 alu_ready SHALL equal (FIFO not full) OR (FIFO empty AND NOT mem_valid); a handshake occurs when alu_valid AND alu_ready.
REQ-019 An accepted ALU result not selected in the same cycle SHALL be enqueued; results SHALL drain in arrival order.
REQ-020 Simultaneous enqueue and dequeue on a full FIFO SHALL NOT be allowed, since alu_ready is low when full; on a non-full FIFO, both SHALL occur and the count SHALL stay unchanged.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH; fifo_count SHALL range from 0 to DEPTH.
REQ-022 A selected write with rd=0 SHALL be consumed with reg_we=0 next cycle.
REQ-023 When nothing is selected, reg_we SHALL be 0 and destreg_num/write_value SHALL hold their previous values.
REQ-024 busy_mask[r] SHALL set on issue_valid with issue_rd=r≠0, and clear at the edge a write to r is selected.
REQ-025 When set and clear hit the same register in one cycle, set SHALL win.
REQ-026 busy_mask[0] SHALL be constantly 0.

Reset
REQ-027 On rst_n low, the block SHALL immediately clear reg_we, destreg_num, write_value, busy_mask, fifo_count, and the FIFO pointers.
REQ-028 Reset mid-operation SHALL discard all queued results without emitting writes.
REQ-029 Outputs SHALL reach their reset values with no clock edge required.

Structure
REQ-030 Package wb_pkg SHALL hold XLEN, REG_ADDR_W=5, and the wb_entry_t struct {rd, data}.
REQ-031 The FIFO SHALL be a sub-module wb_fifo (DEPTH x wb_entry_t, count output).
REQ-032 Selection, output registers, and scoreboard SHALL reside in writeback_ctrl.

Verification
REQ-033 ALU-only bypass: alu rd=5, data=0xDEADBEEF at edge 0 with FIFO empty -> reg_we=1, destreg_num=5, write_value=0xDEADBEEF in cycle 1, fifo_count=0.
REQ-034 Collision: mem (rd=3, 0x11) and alu (rd=4, 0x22) in the same cycle -> rd=3 written in cycle 1, rd=4 in cycle 2, fifo_count peaks at 1.
REQ-035 Full FIFO: mem_valid held high for 6 cycles with alu_valid every cycle -> alu_ready low after 4 enqueues; drains in order once mem_valid drops.
REQ-036 Scoreboard: issue rd=7, then a write to rd=7 with issue rd=7 in the same cycle -> busy_mask[7] stays 1; issue rd=0 -> busy_mask[0] stays 0.
REQ-037 x0 write: alu rd=0, data=0xFFFF -> reg_we stays 0 and alu_ready is high.
REQ-038 Reset with 3 entries queued -> fifo_count=0, busy_mask=0, and no reg_we pulse after release.
